// File: rtl/mam_arb_pkg.sv
// Shared types for the two-master MAM memory arbiter.
//   mam_req_t       : registered copy of a granted request (rw, addr, burst, beats)
//   mam_arb_state_t : arbiter FSM states
//   beat_count()    : number of data beats a request carries
package mam_arb_pkg;

   localparam int ADDR_WIDTH = 32;

   typedef struct packed {
      logic                  rw;
      logic [ADDR_WIDTH-1:0] addr;
      logic                  burst;
      logic [13:0]           beats;
   } mam_req_t;

   typedef enum logic [1:0] {IDLE, REQ, WRITE, READ} mam_arb_state_t;

   // A burst of zero beats still moves one beat.
   function automatic logic [13:0] beat_count(input logic burst, input logic [13:0] beats);
      return (burst && beats != 14'd0) ? beats : 14'd1;
   endfunction

endpackage

// File: rtl/mam_rr_arb2.sv
// Two-way round-robin winner select.
//   valid    : request valid per master
//   done     : pulse when the granted transaction finishes its last beat
//   done_sel : master that owned the finishing transaction
//   win      : winning master index (only meaningful when |valid)
//   prio     : master favoured on a tie
module mam_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   input  logic       done,
   input  logic       done_sel,
   output logic       win,
   output logic       prio
);

   // A lone requester always wins; on a tie the prio master wins.
   always_comb begin
      win = (valid == 2'b11) ? prio : valid[1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      prio <= 1'b0;
      else if (done) prio <= ~done_sel;
   end

endmodule

// File: rtl/mam_mem_arbiter.sv
// Shares one MAM memory port between two masters, granting whole
// transactions in round-robin order.
//   clk, rst   : clock, asynchronous active-low reset
//   s0_*, s1_* : requester ports (req / write / read channels)
//   m_*        : memory port (req / write / read channels)
module mam_mem_arbiter
   import mam_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s0_req_valid,
   output logic                    s0_req_ready,
   input  logic                    s0_req_rw,
   input  logic [ADDR_WIDTH-1:0]   s0_req_addr,
   input  logic                    s0_req_burst,
   input  logic [13:0]             s0_req_beats,
   input  logic                    s0_write_valid,
   input  logic [DATA_WIDTH-1:0]   s0_write_data,
   input  logic [DATA_WIDTH/8-1:0] s0_write_strb,
   output logic                    s0_write_ready,
   output logic                    s0_read_valid,
   output logic [DATA_WIDTH-1:0]   s0_read_data,
   input  logic                    s0_read_ready,
   input  logic                    s1_req_valid,
   output logic                    s1_req_ready,
   input  logic                    s1_req_rw,
   input  logic [ADDR_WIDTH-1:0]   s1_req_addr,
   input  logic                    s1_req_burst,
   input  logic [13:0]             s1_req_beats,
   input  logic                    s1_write_valid,
   input  logic [DATA_WIDTH-1:0]   s1_write_data,
   input  logic [DATA_WIDTH/8-1:0] s1_write_strb,
   output logic                    s1_write_ready,
   output logic                    s1_read_valid,
   output logic [DATA_WIDTH-1:0]   s1_read_data,
   input  logic                    s1_read_ready,
   output logic                    m_req_valid,
   input  logic                    m_req_ready,
   output logic                    m_req_rw,
   output logic [ADDR_WIDTH-1:0]   m_req_addr,
   output logic                    m_req_burst,
   output logic [13:0]             m_req_beats,
   output logic                    m_write_valid,
   output logic [DATA_WIDTH-1:0]   m_write_data,
   output logic [DATA_WIDTH/8-1:0] m_write_strb,
   input  logic                    m_write_ready,
   input  logic                    m_read_valid,
   input  logic [DATA_WIDTH-1:0]   m_read_data,
   output logic                    m_read_ready
);

   localparam int SW = DATA_WIDTH/8;

   mam_arb_state_t        state_q, state_d;
   mam_req_t              req_q;
   logic                  sel_q;
   logic [13:0]           cnt_q;
   logic                  win, prio, start, beat_fire, last_beat;

   // Per-master views so the datapath can index by sel_q / win.
   logic [1:0]            req_valid_v, wvalid_in, rready_in;
   mam_req_t              req_in   [2];
   logic [DATA_WIDTH-1:0] wdata_in [2];
   logic [SW-1:0]         wstrb_in [2];
   logic [1:0]            req_ready_o, write_ready_o, read_valid_o;
   logic [DATA_WIDTH-1:0] read_data_o [2];

   assign req_valid_v = {s1_req_valid, s0_req_valid};
   assign wvalid_in   = {s1_write_valid, s0_write_valid};
   assign rready_in   = {s1_read_ready, s0_read_ready};
   assign req_in[0]   = {s0_req_rw, s0_req_addr, s0_req_burst, s0_req_beats};
   assign req_in[1]   = {s1_req_rw, s1_req_addr, s1_req_burst, s1_req_beats};
   assign wdata_in[0] = s0_write_data;
   assign wdata_in[1] = s1_write_data;
   assign wstrb_in[0] = s0_write_strb;
   assign wstrb_in[1] = s1_write_strb;

   assign {s1_req_ready,   s0_req_ready}   = req_ready_o;
   assign {s1_write_ready, s0_write_ready} = write_ready_o;
   assign {s1_read_valid,  s0_read_valid}  = read_valid_o;
   assign s0_read_data = read_data_o[0];
   assign s1_read_data = read_data_o[1];

   assign start     = (state_q == IDLE) && (|req_valid_v);
   assign last_beat = beat_fire && (cnt_q == 14'd1);

   mam_rr_arb2 u_rr (
      .clk      (clk),
      .rst      (rst),
      .valid    (req_valid_v),
      .done     (last_beat),
      .done_sel (sel_q),
      .win      (win),
      .prio     (prio)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      req_ready_o   = '0;
      write_ready_o = '0;
      read_valid_o  = '0;
      read_data_o[0] = '0;
      read_data_o[1] = '0;
      m_req_valid   = 1'b0;
      m_req_rw      = 1'b0;
      m_req_addr    = '0;
      m_req_burst   = 1'b0;
      m_req_beats   = '0;
      m_write_valid = 1'b0;
      m_write_data  = '0;
      m_write_strb  = '0;
      m_read_ready  = 1'b0;
      beat_fire     = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req_valid_v) begin
               req_ready_o[win] = 1'b1;
               state_d          = REQ;
            end
         end
         REQ: begin
            m_req_valid = 1'b1;
            m_req_rw    = req_q.rw;
            m_req_addr  = req_q.addr;
            m_req_burst = req_q.burst;
            m_req_beats = req_q.beats;
            if (m_req_ready) state_d = req_q.rw ? WRITE : READ;
         end
         WRITE: begin
            m_write_valid        = wvalid_in[sel_q];
            m_write_data         = wdata_in[sel_q];
            m_write_strb         = wstrb_in[sel_q];
            write_ready_o[sel_q] = m_write_ready;
            beat_fire            = wvalid_in[sel_q] && m_write_ready;
         end
         READ: begin
            read_valid_o[sel_q] = m_read_valid;
            read_data_o[sel_q]  = m_read_data;
            m_read_ready        = rready_in[sel_q];
            beat_fire           = m_read_valid && rready_in[sel_q];
         end
         default: state_d = IDLE;
      endcase
      if (beat_fire && cnt_q == 14'd1) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel_q <= 1'b0;
         req_q <= '0;
         cnt_q <= '0;
      end else if (start) begin
         sel_q <= win;
         req_q <= req_in[win];
         cnt_q <= beat_count(req_in[win].burst, req_in[win].beats);
      end else if (beat_fire) begin
         cnt_q <= cnt_q - 14'd1;
      end
   end

endmodule
